// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a small byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between d7 and stop.
//
// state  | meaning
// IDLE   | line high, waiting for a byte in the FIFO
// START  | start bit (0) on the line
// DATA   | data bits d0..d7
// PARITY | even parity of d0..d7 (UART_TX_PARITY_EN only)
// STOP   | stop bit (1); chains straight into START when more data is queued
module uart_tx_fifo #(
  parameter int DIVISOR    = 217,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  out_ready,
  output logic                  out_uart_tx,
  output logic                  out_busy,
  output logic [DEPTH_LOG2:0]   out_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t        FULL_COUNT = cnt_t'(DEPTH);
  localparam logic [15:0] DIV_RELOAD = 16'(DIVISOR - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0] mem [DEPTH];
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  cnt_t       count;
  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic [7:0] head;

  state_t      state, state_nxt;
  logic [15:0] div_cnt, div_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [7:0]  shift_q, shift_nxt;
  logic        tx_q, tx_nxt;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_nxt;
`endif

  assign out_ready   = count < FULL_COUNT;
  assign push        = in_valid && out_ready && !reset;
  assign fifo_empty  = (count == '0);
  assign head        = mem[rd_ptr];
  assign bit_end     = (div_cnt == 16'd0);
  assign out_count   = count;
  assign out_busy    = !fifo_empty || (state != IDLE);
  assign out_uart_tx = tx_q;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // A write while full never reaches here because out_ready is already low.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= 16'd0;
      bit_cnt <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shift_q <= shift_nxt;
      tx_q    <= tx_nxt;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = bit_end ? DIV_RELOAD : div_cnt - 16'd1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_q;
    tx_nxt    = tx_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par_q;
`endif
    case (state)
      IDLE: begin
        tx_nxt  = 1'b1;
        div_nxt = 16'd0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          tx_nxt    = 1'b0;
          div_nxt   = DIV_RELOAD;
          state_nxt = START;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^head;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = 3'd0;
          tx_nxt    = shift_q[0];
          shift_nxt = {1'b0, shift_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = par_q;
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            tx_nxt    = shift_q[0];
            shift_nxt = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = head;
            tx_nxt    = 1'b0;
            state_nxt = START;
`ifdef UART_TX_PARITY_EN
            par_nxt   = ^head;
`endif
          end else begin
            state_nxt = IDLE;
            div_nxt   = 16'd0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: per-cycle comparison against a frame-timeline model
// (FIFO as a queue, frame position as elapsed time) plus directed corner cases.
module tb_uart_tx_fifo;

  localparam int D     = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRB = 11;
`else
  localparam int FRB = 10;
`endif
  localparam int FR = FRB * D;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready, out_uart_tx, out_busy;
  logic [3:0] out_count;

  logic       reset2;
  logic [7:0] in_data2;
  logic       in_valid2;
  logic       out_ready2, out_uart_tx2, out_busy2;
  logic [3:0] out_count2;

  always #5 clock = ~clock;

  uart_tx_fifo #(.DIVISOR(D), .DEPTH_LOG2(3)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_ready(out_ready), .out_uart_tx(out_uart_tx), .out_busy(out_busy),
    .out_count(out_count)
  );

  uart_tx_fifo #(.DIVISOR(2), .DEPTH_LOG2(3)) dut2 (
    .clock(clock), .reset(reset2), .in_data(in_data2), .in_valid(in_valid2),
    .out_ready(out_ready2), .out_uart_tx(out_uart_tx2), .out_busy(out_busy2),
    .out_count(out_count2)
  );

  int total = 0;
  int bad   = 0;

  // Model: queued bytes, byte on the wire, and cycles left in the current frame.
  logic [7:0] q[$];
  logic [7:0] cur = 8'h00;
  int         t_left = 0;

  function automatic logic exp_line(input logic [7:0] b, input int el, input int d);
    int idx = el / d;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (FRB == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic exp_tx;
    @(posedge clock);
    if (reset) begin
      q.delete();
      t_left = 0;
    end else begin
      bit can_push;
      can_push = in_valid && (q.size() < DEPTH);
      if (t_left <= 1) begin
        if (q.size() > 0) begin
          cur    = q.pop_front();
          t_left = FR;
        end else begin
          t_left = 0;
        end
      end else begin
        t_left--;
      end
      if (can_push) q.push_back(in_data);
    end
    #1;
    exp_tx = (t_left == 0) ? 1'b1 : exp_line(cur, FR - t_left, D);
    chk("line",  out_uart_tx, exp_tx);
    chk("busy",  out_busy,  (t_left != 0 || q.size() != 0));
    chk("count", out_count, q.size());
    chk("ready", out_ready, (q.size() < DEPTH));
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((t_left != 0 || q.size() != 0) && n < max) begin
      step();
      n++;
    end
    step();
    chk("drain_busy", out_busy, 1'b0);
    chk("drain_line", out_uart_tx, 1'b1);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    reset2    = 1'b1;
    in_valid2 = 1'b0;
    in_data2  = 8'h00;
    step();
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("rst_line",  out_uart_tx, 1'b1);
    chk("rst_count", out_count, 4'd0);
    chk("rst_busy",  out_busy, 1'b0);
    chk("rst_ready", out_ready, 1'b1);

    // Single byte, then two back-to-back bytes
    push_byte(8'h55);
    chk("first_latency_count", out_count, 4'd1);
    step();
    chk("first_start_bit", out_uart_tx, 1'b0);
    drain(2 * FR);
    push_byte(8'hA5);
    push_byte(8'h3C);
    drain(3 * FR);

    // Hold in_valid across 0x00..0x0A: fills, then overflow bytes are dropped
    for (int b = 0; b <= 10; b++) begin
      in_valid = 1'b1;
      in_data  = 8'(b);
      step();
    end
    in_valid = 1'b0;
    chk("fill_count", out_count, 4'd8);
    chk("fill_ready", out_ready, 1'b0);

    // Push while full on the very edge that pops
    n = 0;
    while (t_left != 1 && n < 2 * FR) begin step(); n++; end
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_valid = 1'b0;
    chk("full_pop_count", out_count, 4'd7);
    drain(10 * FR);

    // Reset in the middle of d3
    push_byte(8'h0F);
    n = 0;
    while (!(t_left != 0 && (FR - t_left) / D == 4) && n < FR) begin step(); n++; end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_line",  out_uart_tx, 1'b1);
    chk("midrst_count", out_count, 4'd0);
    chk("midrst_busy",  out_busy, 1'b0);
    push_byte(8'h81);
    drain(2 * FR);

    // Minimum divisor on the second instance
    reset2 = 1'b0;
    step();
    in_valid2 = 1'b1;
    in_data2  = 8'h01;
    step();
    in_valid2 = 1'b0;
    for (int k = 0; k < FRB * 2; k++) begin
      step();
      chk("d2_line", out_uart_tx2, exp_line(8'h01, k, 2));
      chk("d2_busy", out_busy2, 1'b1);
    end
    step();
    chk("d2_idle_line", out_uart_tx2, 1'b1);
    chk("d2_idle_busy", out_busy2, 1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 9) < ((i < 2000) ? 1 : 7));
      in_data  = 8'($urandom);
      reset    = ($urandom_range(0, 599) == 0);
      step();
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    drain((DEPTH + 2) * FR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DIVISOR, default 217, giving clock cycles per bit (25 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, giving FIFO depth 2^DEPTH_LOG2 bytes; legal range 1..6.
REQ-003 SHALL have port clock, input, 1, the single system clock (clk_25mhz domain).
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, 8, byte to enqueue.
REQ-006 SHALL have port in_valid, input, 1, enqueue request.
REQ-007 SHALL have port out_ready, output, 1, FIFO not full; a byte is accepted when in_valid and out_ready are both high on a rising edge.
REQ-008 SHALL have port out_uart_tx, output, 1, registered serial line (idle high), driven to ftdi_rxd.
REQ-009 SHALL have port out_busy, output, 1, high when the FIFO is non-empty or a frame is in progress.
REQ-010 SHALL have port out_count, output, DEPTH_LOG2+1, current FIFO occupancy.

Function
REQ-011 SHALL transmit 8N1 frames, LSB first: start (0), d0..d7, stop (1), each bit held exactly DIVISOR cycles.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY (only with the macro), STOP.
REQ-013 IDLE -> START on the edge where the FIFO is non-empty; that edge pops the head byte into the shift register and drives out_uart_tx low.
REQ-014 START -> DATA, DATA -> STOP after the 8th bit (or DATA -> PARITY -> STOP), each after DIVISOR cycles; a 16-bit down-counter reloads with DIVISOR-1 at every bit boundary.
REQ-015 STOP -> START directly (no idle bit) if the FIFO is non-empty when the stop bit ends; otherwise STOP -> IDLE.
REQ-016 Latency: a byte written at edge N into an empty FIFO with FSM in IDLE SHALL produce out_uart_tx=0 after edge N+1.
REQ-017 out_ready SHALL be combinational: out_count < 2^DEPTH_LOG2.
REQ-018 A write while full SHALL be dropped with no change to FIFO contents or pointers, even when a pop occurs on the same edge.
REQ-019 Simultaneous accepted push and pop SHALL leave out_count unchanged and preserve FIFO order.
REQ-020 Read/write pointers SHALL be DEPTH_LOG2 bits wide and wrap modulo depth; out_count SHALL never exceed 2^DEPTH_LOG2.
REQ-021 in_data SHALL be ignored while in_valid is low.

Reset
REQ-022 On reset SHALL set: FSM=IDLE, out_uart_tx=1, pointers=0, out_count=0, out_busy=0, bit counter=0, divider=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame and flush the FIFO; out_uart_tx is 1 after that edge.
REQ-024 in_valid during reset SHALL be ignored; out_ready SHALL read 1 after reset releases.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of d0..d7) SHALL be sent in PARITY state between d7 and stop; frame = 11 bit times.
REQ-026 Macro UART_TX_PARITY_EN undefined: PARITY state and its logic SHALL be absent; frame = 10 bit times.

Verification (DIVISOR=4, DEPTH_LOG2=3 unless noted)
REQ-027 Write 0x55 once from reset -> line 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, stop 1 for 4 cycles; out_busy falls after cycle 40 (44 with parity, parity bit 0).
REQ-028 Write 0xA5 then 0x3C back-to-back -> two frames with no idle gap, second start bit immediately after first stop; with parity, parity bits 0 and 0.
REQ-029 Hold in_valid with bytes 0x00..0x0A while transmitting -> first popped immediately, out_ready low at count 8, overflow bytes dropped, transmitted sequence 0x00..0x08 in order.
REQ-030 Full FIFO, push 0xFF on the same edge as a pop -> 0xFF dropped, out_count 8->7.
REQ-031 Assert reset during d3 of 0x0F -> out_uart_tx=1, out_count=0, out_busy=0 after that edge; write 0x81 after release -> clean frame.
REQ-032 DIVISOR=2, 0x01 -> every bit exactly 2 cycles, frame 20 cycles.
